// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the debounce_filter slice.
package debounce_pkg;

  typedef enum logic [0:0] {ST_STABLE, ST_SETTLING} debounce_state_t;

  localparam int unsigned GLITCH_CNT_W = 8;

  // Stability counter width: max(1, clog2(n)); holds values up to n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_filter_sat_counter.sv
// sat_counter: generic saturating up-counter, cleared only by reset.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  // Count up on inc_i, holding at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/debounce_filter.sv
// debounce_filter: debounce and edge-detect stage behind a synchronizer.
// Optional glitch counter output enabled by macro DEBOUNCE_GLITCH_CNT_EN.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
`endif
);

  localparam int unsigned    CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  debounce_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            level_d, rise_d, fall_d;
  logic            differ;

  assign differ = data_i ^ level_o;

  // Next-state logic: qualify runs of differing samples, accept at N.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_o;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (differ) begin
          if (STABLE_CYCLES == 1) begin
            level_d = data_i;
            rise_d  = data_i;
            fall_d  = ~data_i;
          end else begin
            state_d = ST_SETTLING;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_SETTLING: begin
        if (!differ) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          level_d = data_i;
          rise_d  = data_i;
          fall_d  = ~data_i;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops any settling run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_o <= RESET_VAL;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_o <= level_d;
      rise_o  <= rise_d;
      fall_o  <= fall_d;
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // A settling run broken by a sample equal to the current level.
  logic glitch;
  assign glitch = (state_q == ST_SETTLING) && !differ;

  sat_counter #(
    .WIDTH (GLITCH_CNT_W)
  ) u_glitch_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (glitch),
    .count_o (glitch_cnt_o)
  );
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter: four debounce_filter instances (N=4, N=4/RESET_VAL=1,
// N=1, N=16) on shared stimulus, checked against a run-length model.
module tb_debounce_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data = 1'b0;

  logic       lv [4];
  logic       ri [4];
  logic       fa [4];
  logic [7:0] gc [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debounce_filter #(.STABLE_CYCLES(4), .RESET_VAL(1'b0)) u4 (
    .clk_i(clk), .rst_i(rst), .data_i(data),
    .level_o(lv[0]), .rise_o(ri[0]), .fall_o(fa[0])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(gc[0])
`endif
  );
  debounce_filter #(.STABLE_CYCLES(4), .RESET_VAL(1'b1)) u4r (
    .clk_i(clk), .rst_i(rst), .data_i(data),
    .level_o(lv[1]), .rise_o(ri[1]), .fall_o(fa[1])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(gc[1])
`endif
  );
  debounce_filter #(.STABLE_CYCLES(1), .RESET_VAL(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst), .data_i(data),
    .level_o(lv[2]), .rise_o(ri[2]), .fall_o(fa[2])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(gc[2])
`endif
  );
  debounce_filter #(.STABLE_CYCLES(16), .RESET_VAL(1'b0)) u16 (
    .clk_i(clk), .rst_i(rst), .data_i(data),
    .level_o(lv[3]), .rise_o(ri[3]), .fall_o(fa[3])
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(gc[3])
`endif
  );

`ifndef DEBOUNCE_GLITCH_CNT_EN
  initial for (int i = 0; i < 4; i++) gc[i] = '0;
`endif

  // Reference model: length of the current run of samples differing
  // from the published level; accepted once the run reaches N.
  typedef struct {
    bit lvl;
    int run;
    int gcnt;
    bit rise;
    bit fall;
  } mst_t;

  int nval [4] = '{4, 4, 1, 16};
  bit rval [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  mst_t m [4];

  function automatic mst_t mreset(input bit rv);
    mst_t r;
    r.lvl = rv; r.run = 0; r.gcnt = 0; r.rise = 0; r.fall = 0;
    return r;
  endfunction

  function automatic mst_t mstep(input mst_t s, input bit d, input int n);
    mst_t r = s;
    r.rise = 0;
    r.fall = 0;
    if (d != s.lvl) begin
      r.run = s.run + 1;
      if (r.run == n) begin
        r.lvl  = d;
        r.rise = d;
        r.fall = !d;
        r.run  = 0;
      end
    end else begin
      if (s.run > 0) r.gcnt = (s.gcnt < 255) ? s.gcnt + 1 : 255;
      r.run = 0;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // One clock: advance the model with the sampled inputs, then compare.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      m[i] = rst ? mreset(rval[i]) : mstep(m[i], data, nval[i]);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("level%0d", i), 32'(lv[i]), 32'(m[i].lvl));
      chk($sformatf("rise%0d", i), 32'(ri[i]), 32'(m[i].rise));
      chk($sformatf("fall%0d", i), 32'(fa[i]), 32'(m[i].fall));
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk($sformatf("gcnt%0d", i), 32'(gc[i]), 32'(m[i].gcnt));
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit d;
    bit l;
    bit r;
    bit f;
  } vec_t;

  function automatic vec_t mk(input bit d, input bit l, input bit r, input bit f);
    vec_t v;
    v.d = d; v.l = l; v.r = r; v.f = f;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    bit   d;
    int   len;
    int   cyc;

    for (int i = 0; i < 4; i++) m[i] = mreset(rval[i]);

    // Reset defaults and async assert on the RESET_VAL=1 instance.
    rst = 1'b1; data = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("u4r_low_before_rst", 32'(lv[1]), 0);
    #2 rst = 1'b1;
    #1;
    chk("u4r_async_level", 32'(lv[1]), 1);
    chk("u4r_async_rise", 32'(ri[1]), 0);
    chk("u4r_async_fall", 32'(fa[1]), 0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("u4r_fall_level", 32'(lv[1]), (k < 4) ? 1 : 0);
      chk("u4r_fall_pulse", 32'(fa[1]), (k == 4) ? 1 : 0);
    end

    // Table: clean rise, clean fall, then restart after a glitch (N=4).
    tbl.push_back(mk(1, 0, 0, 0)); tbl.push_back(mk(1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0)); tbl.push_back(mk(1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0)); tbl.push_back(mk(1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0)); tbl.push_back(mk(0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0)); tbl.push_back(mk(0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0)); tbl.push_back(mk(1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0)); tbl.push_back(mk(1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0)); tbl.push_back(mk(1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0)); tbl.push_back(mk(1, 1, 0, 0));
    foreach (tbl[i]) begin
      data = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d_level", i), 32'(lv[0]), 32'(tbl[i].l));
      chk($sformatf("tbl%0d_rise", i), 32'(ri[0]), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_fall", i), 32'(fa[0]), 32'(tbl[i].f));
    end

    // Glitch rejection and saturation (N=4).
    data = 1'b0;
    do_reset();
    data = 1'b1; repeat (3) tick();
    data = 1'b0; tick();
    chk("glitch_level", 32'(lv[0]), 0);
    chk("glitch_rise", 32'(ri[0]), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt_one", 32'(gc[0]), 1);
`endif
    repeat (300) begin
      data = 1'b1; repeat (3) tick();
      data = 1'b0; tick();
    end
    chk("glitch_many_level", 32'(lv[0]), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt_sat", 32'(gc[0]), 255);
    chk("n1_glitch_cnt", 32'(gc[2]), 0);
`endif

    // N=1 passthrough with toggling input.
    d = !m[2].lvl;
    for (int k = 0; k < 20; k++) begin
      data = d;
      tick();
      chk("n1_level", 32'(lv[2]), 32'(d));
      chk("n1_rise", 32'(ri[2]), 32'(d));
      chk("n1_fall", 32'(fa[2]), 32'(!d));
      d = !d;
    end

    // Reset in the middle of a settling run (N=16).
    data = 1'b0;
    do_reset();
    data = 1'b1;
    repeat (10) tick();
    chk("n16_pre_level", 32'(lv[3]), 0);
    #2 rst = 1'b1;
    tick();
    chk("n16_rst_level", 32'(lv[3]), 0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("n16_level", 32'(lv[3]), (k >= 16) ? 1 : 0);
      chk("n16_rise", 32'(ri[3]), (k == 16) ? 1 : 0);
    end

    // Randomized runs with occasional asynchronous resets.
    cyc = 0;
    while (cyc < 4000) begin
      data = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
      repeat (len) begin
        tick();
        cyc++;
      end
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
